cla_seq_adder: RTL and testbench

Multi-cycle add/subtract sequencer that computes a WIDTH-bit sum or difference by reusing a single 4-bit carry-lookahead slice over WIDTH/4 clock cycles, least-significant nibble first. It sits between the CPU control unit and the register-file write path. It trades latency for area on small FPGA targets. Operands and results are exchanged over a valid/ready handshake on each side.

---
 rtl/cla_seq_adder_pkg.sv | 12 +
 rtl/cla_seq_adder_cla4_slice.sv | 29 ++
 rtl/cla_seq_adder.sv | 84 ++++++++
 tb/tb_cla_seq_adder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_adder_pkg.sv
// Shared encodings for the nibble-serial add/subtract sequencer.
package cla_seq_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_seq_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice with carry-in.
module cla4_slice
  import cla_seq_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W-1:0] g, p;
  logic [NIB_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded directly from g/p/cin; no ripple between bits.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[NIB_W-1:0];
  assign cout = c[NIB_W];

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit add/subtract computed one nibble per clock through a shared CLA slice.
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             c_reg;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg;
  logic [NIB_W-1:0] s_sum;
  logic             s_cout;

  cla4_slice u_slice (
    .a    (a_reg[idx*NIB_W +: NIB_W]),
    .b    (b_reg[idx*NIB_W +: NIB_W]),
    .cin  (c_reg),
    .sum  (s_sum),
    .cout (s_cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = RUN;
      RUN:     if (idx == LAST)  state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // B is stored pre-inverted for subtract so the slice only ever adds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      c_reg      <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else if (state == IDLE && in_valid) begin
      idx        <= '0;
      c_reg      <= sub;
      a_reg      <= a;
      b_reg      <= b ^ {WIDTH{sub}};
      result_reg <= '0;
    end else if (state == RUN) begin
      result_reg[idx*NIB_W +: NIB_W] <= s_sum;
      c_reg <= s_cout;
      idx   <= (idx == LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_reg;
  assign cout      = c_reg;
  assign zero      = ~|result_reg;
  assign ovf       = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (result_reg[WIDTH-1] != a_reg[WIDTH-1]);

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: directed corner cases, back-pressure, reset, random traffic.
module tb_cla_seq_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, sub, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, result;
  logic             cout, ovf, zero;

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] r;
    logic             c, o, z;
    int               acc;
  } exp_t;

  exp_t             sb[$];
  int               total = 0, bad = 0, n_acc = 0;
  logic             ov_prev = 1'b0;
  logic [WIDTH-1:0] last_res, held;
  logic             last_c, last_o, last_z;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    exp_t e;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] yy;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, s};
    e.r = t[WIDTH-1:0];
    e.c = t[WIDTH];
    e.o = (x[WIDTH-1] == yy[WIDTH-1]) && (e.r[WIDTH-1] != x[WIDTH-1]);
    e.z = (e.r == '0);
    e.acc = 0;
    return e;
  endfunction

  // Called at a negedge: drive inputs, check/consume outputs, log acceptance, advance one cycle.
  task automatic tick(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                      input logic is, input logic ordy);
    exp_t e;
    in_valid = iv; a = ia; b = ib; sub = is; out_ready = ordy;
    #1;
    if (out_valid && !ov_prev) begin
      if (sb.size() == 0) chk("spurious_valid", out_valid, 0);
      else                chk("latency", cyc - sb[0].acc, NIB);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", out_valid, 0);
      else begin
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("cout", cout, e.c);
        chk("ovf", ovf, e.o);
        chk("zero", zero, e.z);
        last_res = result; last_c = cout; last_o = ovf; last_z = zero;
      end
    end
    if (in_valid && in_ready) begin
      e = model(ia, ib, is);
      e.acc = cyc + 1;
      sb.push_back(e);
      n_acc++;
    end
    ov_prev = out_valid;
    @(negedge clk);
  endtask

  task automatic accept(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      got = in_ready;
      tick(1'b1, x, y, s, 1'b1);
    end
    if (!got) chk("accept_timeout", in_ready, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sb.size() > 0; n++) tick(1'b0, '0, '0, 1'b0, 1'b1);
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    accept(x, y, s);
    drain();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed corners
    do_op(16'h00FF, 16'h0001, 1'b0);
    chk("d1_res", last_res, 16'h0100); chk("d1_c", last_c, 0); chk("d1_o", last_o, 0); chk("d1_z", last_z, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0);
    chk("d2_res", last_res, 16'h8000); chk("d2_o", last_o, 1); chk("d2_c", last_c, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0);
    chk("d3_res", last_res, 16'h0000); chk("d3_c", last_c, 1); chk("d3_z", last_z, 1); chk("d3_o", last_o, 0);
    do_op(16'h1234, 16'h1234, 1'b1);
    chk("d4_res", last_res, 16'h0000); chk("d4_c", last_c, 1); chk("d4_z", last_z, 1);
    do_op(16'h0000, 16'h0001, 1'b1);
    chk("d5_res", last_res, 16'hFFFF); chk("d5_c", last_c, 0);
    do_op(16'h8000, 16'h0001, 1'b1);
    chk("d6_res", last_res, 16'h7FFF); chk("d6_o", last_o, 1);

    // Back-pressure with fresh operands offered the whole time
    accept(16'h0102, 16'h0304, 1'b0);
    for (int n = 0; n < 20 && !out_valid; n++) tick(1'b0, '0, '0, 1'b0, 1'b0);
    held = result;
    chk("bp_valid", out_valid, 1);
    chk("bp_first", held, 16'h0406);
    for (int n = 0; n < 10; n++) begin
      tick(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b1, 1'b0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", result, held);
    end
    tick(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1);
    chk("bp_back_idle", in_ready, 1);
    tick(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1);
    chk("bp_next_acc", in_ready, 0);
    drain();
    chk("bp_next_res", last_res, 16'h3333);

    // Reset two nibble edges into a run
    accept(16'hFFFF, 16'h0001, 1'b0);
    tick(1'b0, '0, '0, 1'b0, 1'b1);
    tick(1'b0, '0, '0, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_result", result, 0);
    chk("mr_zero", zero, 1);
    sb.delete();
    ov_prev = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(16'h0003, 16'h0004, 1'b0);
    chk("mr_next_res", last_res, 16'h0007);
    chk("mr_next_c", last_c, 0);

    // Random traffic with gaps on both sides
    n_acc = 0;
    for (int n = 0; n < 40000 && n_acc < 1000; n++)
      tick($urandom_range(0, 3) != 0, WIDTH'($urandom), WIDTH'($urandom),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    if (n_acc < 1000) chk("rand_budget", n_acc, 1000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
